// File: rtl/tcdm_stall_responder_if.sv
// TCDM channel bundle between the streamer (master) and a TCDM target (slave).
// Every signal carries one lane per channel.
//   req     : request per channel
//   gnt     : grant per channel (combinational in the target)
//   add     : byte address per channel
//   wen     : 1 = read, 0 = write
//   be      : byte enables for writes
//   data    : write data
//   r_data  : read data (registered in the target)
//   r_valid : read-data valid (registered in the target)
interface tcdm_stall_responder_if #(
    parameter int unsigned MP = 4
);
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] data;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/tcdm_stall_responder.sv
// Multi-port TCDM target for the streamer's word-interleaved requests.
// Grants requests (optionally with pseudo-random stalls), stores byte-enabled
// writes and returns read data one cycle after grant.
//
// Optional feature macro: TCDM_RESP_STALL_EN
//   defined   : per-channel 16-bit LFSRs inject grant stalls
//   undefined : gnt = req, stallable_i / stall_thresh_i ignored
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   stallable_i    : allows stall injection when high
//   stall_thresh_i : stall probability = stall_thresh_i/256
//   tcdm           : TCDM channel bundle (slave side), MP channels
//   err_o          : sticky out-of-range access flag
//
// The memory array mem_q is not reset; benches may preload it hierarchically.
module tcdm_stall_responder #(
    parameter int unsigned MP        = 4,
    parameter int unsigned MEM_WORDS = 16384,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallable_i,
    input  logic [7:0]            stall_thresh_i,
    tcdm_stall_responder_if.slave tcdm,
    output logic                  err_o
);
    localparam int unsigned IW = $clog2(MEM_WORDS);

    logic [31:0]           mem_q [MEM_WORDS];
    logic [MP-1:0]         gnt;
    logic [MP-1:0]         rd_gnt;
    logic [MP-1:0]         wr_en;
    logic [MP-1:0]         oor;
    logic [MP-1:0][IW-1:0] idx;
    logic [MP-1:0][31:0]   r_data_q;
    logic [MP-1:0]         r_valid_q;
    logic                  err_q;

    // Word index and out-of-range detection per channel.
    always_comb begin
        for (int unsigned i = 0; i < MP; i++) begin
            idx[i] = tcdm.add[i][2 +: IW];
            oor[i] = (tcdm.add[i] >> (IW + 2)) != '0;
        end
    end

`ifdef TCDM_RESP_STALL_EN
    logic [MP-1:0][15:0] lfsr_q;
    logic [MP-1:0]       stall;

    always_comb begin
        for (int unsigned i = 0; i < MP; i++) begin
            stall[i] = stallable_i && (lfsr_q[i][7:0] < stall_thresh_i);
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11; advances only while the channel requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MP; i++) begin
                lfsr_q[i] <= LFSR_SEED ^ 16'(i + 1);
            end
        end else begin
            for (int unsigned i = 0; i < MP; i++) begin
                if (tcdm.req[i]) begin
                    lfsr_q[i] <= {lfsr_q[i][14:0],
                                  lfsr_q[i][15] ^ lfsr_q[i][13] ^ lfsr_q[i][12] ^ lfsr_q[i][10]};
                end
            end
        end
    end

    assign gnt = tcdm.req & ~stall;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = stallable_i ^ (^stall_thresh_i);

    assign gnt = tcdm.req;
`endif

    assign rd_gnt = gnt & tcdm.wen;

    // Writes are suppressed in any cycle where reset is held at the clock edge.
    always_comb begin
        for (int unsigned i = 0; i < MP; i++) begin
            wr_en[i] = gnt[i] & ~tcdm.wen[i] & ~rst_i;
        end
    end

    // Channels are visited in ascending order so the highest channel's
    // nonblocking update lands last and wins on overlapping bytes.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < MP; i++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_en[i] && tcdm.be[i][b]) begin
                    mem_q[idx[i]][8*b +: 8] <= tcdm.data[i][8*b +: 8];
                end
            end
        end
    end

    // Reads sample mem_q before this edge's writes commit, so a same-cycle
    // read/write collision returns the pre-write word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= rd_gnt;
            for (int unsigned i = 0; i < MP; i++) begin
                if (rd_gnt[i]) begin
                    r_data_q[i] <= mem_q[idx[i]];
                end
            end
            if ((gnt & oor) != '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tcdm.gnt     = gnt;
    assign tcdm.r_data  = r_data_q;
    assign tcdm.r_valid = r_valid_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_tcdm_stall_responder.sv
`timescale 1ns/1ps
module tb_tcdm_stall_responder;
    localparam int unsigned MP        = 4;
    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       stallable;
    logic [7:0] thresh;
    logic       err;

    tcdm_stall_responder_if #(.MP(MP)) tcdm ();

    tcdm_stall_responder #(
        .MP(MP),
        .MEM_WORDS(MEM_WORDS),
        .LFSR_SEED(SEED)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .stallable_i(stallable),
        .stall_thresh_i(thresh),
        .tcdm(tcdm),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [31:0]   m_mem  [MEM_WORDS];
    logic [31:0]   m_rd   [MP];
    logic [MP-1:0] m_rv;
    logic          m_err;
    logic [15:0]   m_lfsr [MP];

    int gcnt [MP];
    int vcnt [MP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Per-cycle comparison against the model; predicts the next edge's results.
    always @(negedge clk) begin
        logic [MP-1:0] eg;
        logic [MP-1:0] nrv;
        logic          st;
        int unsigned   w;
        if (rst) begin
            m_rv  = '0;
            m_err = 1'b0;
            for (int i = 0; i < MP; i++) begin
                m_rd[i]   = '0;
                m_lfsr[i] = SEED ^ 16'(i + 1);
            end
        end
        check("r_valid", 32'(tcdm.r_valid), 32'(m_rv));
        for (int i = 0; i < MP; i++) begin
            check("r_data", tcdm.r_data[i], m_rd[i]);
        end
        check("err", 32'(err), 32'(m_err));
        for (int i = 0; i < MP; i++) begin
`ifdef TCDM_RESP_STALL_EN
            st = stallable && (m_lfsr[i][7:0] < thresh);
`else
            st = 1'b0;
`endif
            eg[i] = tcdm.req[i] && !st;
        end
        check("gnt", 32'(tcdm.gnt), 32'(eg));
        nrv = '0;
        if (!rst) begin
            for (int i = 0; i < MP; i++) begin
                w = (tcdm.add[i] >> 2) % MEM_WORDS;
                if (eg[i] && tcdm.wen[i]) begin
                    nrv[i]  = 1'b1;
                    m_rd[i] = m_mem[w];
                end
                if (eg[i] && tcdm.add[i] >= MEM_WORDS * 4) m_err = 1'b1;
            end
            for (int i = 0; i < MP; i++) begin
                w = (tcdm.add[i] >> 2) % MEM_WORDS;
                if (eg[i] && !tcdm.wen[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (tcdm.be[i][b]) m_mem[w][8*b +: 8] = tcdm.data[i][8*b +: 8];
                    end
                end
            end
            for (int i = 0; i < MP; i++) begin
                if (tcdm.req[i]) m_lfsr[i] = lfsr_next(m_lfsr[i]);
            end
            m_rv = nrv;
        end
    end

    task automatic idle();
        tcdm.req  = '0;
        tcdm.wen  = '1;
        tcdm.add  = '0;
        tcdm.be   = '0;
        tcdm.data = '0;
    endtask

    task automatic wr(input int ch, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        tcdm.req[ch]  = 1'b1;
        tcdm.wen[ch]  = 1'b0;
        tcdm.add[ch]  = a;
        tcdm.data[ch] = d;
        tcdm.be[ch]   = be;
    endtask

    task automatic rd(input int ch, input logic [31:0] a);
        tcdm.req[ch] = 1'b1;
        tcdm.wen[ch] = 1'b1;
        tcdm.add[ch] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        step();
        idle();
    endtask

    // Holds read requests on all channels; a channel moves to the next address only once granted.
    task automatic stress(input int n);
        logic [31:0]   a [MP];
        logic [MP-1:0] g;
        for (int i = 0; i < MP; i++) begin
            gcnt[i] = 0;
            vcnt[i] = 0;
            a[i]    = 32'(i * 256);
            rd(i, a[i]);
        end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            g = tcdm.req & tcdm.gnt;
            for (int i = 0; i < MP; i++) begin
                if (g[i]) gcnt[i]++;
                if (tcdm.r_valid[i]) vcnt[i]++;
            end
            step();
            for (int i = 0; i < MP; i++) begin
                if (g[i]) begin
                    a[i] = (a[i] + 4) % (MEM_WORDS * 4);
                    rd(i, a[i]);
                end
            end
        end
        idle();
        @(negedge clk);
        for (int i = 0; i < MP; i++) begin
            if (tcdm.r_valid[i]) vcnt[i]++;
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        stallable = 1'b0;
        thresh    = 8'd0;
        idle();
        for (int k = 0; k < MEM_WORDS; k++) begin
            m_mem[k]     = 32'hC0DE_0000 | 32'(k);
            dut.mem_q[k] = 32'hC0DE_0000 | 32'(k);
        end
        m_rv  = '0;
        m_err = 1'b0;
        for (int i = 0; i < MP; i++) begin
            m_rd[i]   = '0;
            m_lfsr[i] = SEED ^ 16'(i + 1);
        end
        tcdm.req = '1;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(tcdm.gnt), 32'hF);
        check("rst_rvalid", 32'(tcdm.r_valid), 32'h0);
        check("rst_rdata0", tcdm.r_data[0], 32'h0);
        check("rst_err", 32'(err), 32'h0);
        step();
        idle();
        rst = 1'b0;
        step();

        // 1: full-word write then read
        wr(0, 32'h40, 32'hDEADBEEF, 4'hF);
        issue();
        rd(0, 32'h40);
        issue();
        @(negedge clk);
        check("s1_rvalid", 32'(tcdm.r_valid[0]), 32'h1);
        check("s1_rdata", tcdm.r_data[0], 32'hDEADBEEF);
        step();

        // 2: partial byte-enable write over zero
        dut.mem_q[32] = 32'h0;
        m_mem[32]     = 32'h0;
        wr(0, 32'h80, 32'h11223344, 4'b0101);
        issue();
        rd(2, 32'h80);
        issue();
        @(negedge clk);
        check("s2_rdata", tcdm.r_data[2], 32'h00220044);
        step();

        // 3: write/write and read/write collisions
        wr(1, 32'h100, 32'd1, 4'hF);
        wr(3, 32'h100, 32'd3, 4'hF);
        issue();
        rd(1, 32'h100);
        issue();
        @(negedge clk);
        check("s3_ww_high_wins", tcdm.r_data[1], 32'd3);
        step();
        rd(0, 32'h100);
        wr(2, 32'h100, 32'd7, 4'hF);
        issue();
        @(negedge clk);
        check("s3_rw_old", tcdm.r_data[0], 32'd3);
        step();
        rd(3, 32'h100);
        issue();
        @(negedge clk);
        check("s3_rw_new", tcdm.r_data[3], 32'd7);
        step();

        // 4: out-of-range read wraps and sets sticky err
        rd(1, MEM_WORDS * 4 + 8);
        issue();
        @(negedge clk);
        check("s4_wrap_rdata", tcdm.r_data[1], 32'hC0DE0002);
        check("s4_err", 32'(err), 32'h1);
        step();
        repeat (3) step();
        @(negedge clk);
        check("s4_err_sticky", 32'(err), 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("s4_err_cleared", 32'(err), 32'h0);
        step();

        // 6: reset in the cycle after a granted read
        wr(0, 32'h200, 32'h5555AAAA, 4'hF);
        issue();
        rd(0, 32'h200);
        step();
        idle();
        rst = 1'b1;
        wr(1, 32'h200, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        check("s6_rvalid_dropped", 32'(tcdm.r_valid), 32'h0);
        step();
        idle();
        rst = 1'b0;
        step();
        rd(2, 32'h200);
        issue();
        @(negedge clk);
        check("s6_mem_kept", tcdm.r_data[2], 32'h5555AAAA);
        step();

        // 5: stall injection with held requests
        stallable = 1'b1;
        thresh    = 8'd26;
        stress(10000);
        for (int i = 0; i < MP; i++) begin
`ifdef TCDM_RESP_STALL_EN
            check("s5_ratio_in_band",
                  32'((gcnt[i] * 100 >= 88 * 10000) && (gcnt[i] * 100 <= 92 * 10000)), 32'h1);
`else
            check("s5_all_granted", 32'(gcnt[i]), 32'd10000);
`endif
            check("s5_rvalid_per_grant", 32'(vcnt[i]), 32'(gcnt[i]));
        end
        thresh = 8'd0;
        stress(1000);
        for (int i = 0; i < MP; i++) begin
            check("s5_thresh0_grants", 32'(gcnt[i]), 32'd1000);
            check("s5_thresh0_rvalid", 32'(vcnt[i]), 32'd1000);
        end
        stallable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tcdm_stall_responder.md
# tcdm_stall_responder

Synthesizable multi-port TCDM target that answers the streamer's word-interleaved TCDM requests: it grants, stores byte-enabled writes, and returns read data one cycle after grant. It sits in the accelerator bench and FPGA harness at the memory end of the streamer's `tcdm` port (split into `MP` 32-bit channels), replacing the behavioural memory model. It also injects pseudo-random grant stalls to stress the streamer's handshakes.

## Interface
- `MP`, 4: number of 32-bit TCDM channels.
- `MEM_WORDS`, 16384: memory depth in 32-bit words, power of two.
- `LFSR_SEED`, 16'hACE1: base seed for the per-channel stall LFSRs.
- `clk_i` in 1: clock; all logic is rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `stallable_i` in 1: allows stall injection when high.
- `stall_thresh_i` in 8: stall probability is `stall_thresh_i`/256; 0 means no stalls.
- `tcdm_req_i` in MP: request per channel.
- `tcdm_gnt_o` out MP: grant per channel, combinational.
- `tcdm_add_i` in MP×32: byte address per channel.
- `tcdm_wen_i` in MP: 1 = read, 0 = write.
- `tcdm_be_i` in MP×4: byte enables for writes.
- `tcdm_data_i` in MP×32: write data.
- `tcdm_r_data_o` out MP×32: read data, registered.
- `tcdm_r_valid_o` out MP: read-data valid, registered.
- `err_o` out 1: sticky out-of-range access flag.

## Operation
- A channel `i` access is granted when `tcdm_req_i[i] & tcdm_gnt_o[i]`. Ungranted requests have no effect.
- Word index is `tcdm_add_i[i][2 +: $clog2(MEM_WORDS)]`. Address bits [1:0] are ignored.
- If any address bit above the index range is set on a granted access:
  - the access is still performed, using the truncated index;
  - `err_o` sets and stays set until reset.
- Granted write: updates each byte `b` with `tcdm_be_i[i][b]=1`. It produces no r_valid.
- Granted read: the next cycle drives `tcdm_r_valid_o[i]=1` and `tcdm_r_data_o[i]` = word contents. Outside such cycles, r_valid is 0 and r_data holds its last value.
- Same-cycle collisions:
  - several writes to the same word: on overlapping enabled bytes, the highest channel index wins;
  - read and write to the same word: the read returns the pre-write contents.
- Memory array contents are not reset. After reset, contents are preserved; the bench preloads them by hierarchical access to `mem_q`.
- Stall generator, per channel:
  - a 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded with `LFSR_SEED ^ (i+1)`;
  - it advances every cycle in which `tcdm_req_i[i]` is high;
  - `stall[i] = stallable_i && (lfsr[i][7:0] < stall_thresh_i)`;
  - `tcdm_gnt_o[i] = tcdm_req_i[i] & ~stall[i]`;
  - a stalled request must be held by the initiator and is granted in a later cycle.

## Timing
- Reset values: `tcdm_gnt_o` follows req (no stall, since LFSRs are at seed and `stallable_i` is ANDed); `tcdm_r_valid_o`='0; `tcdm_r_data_o`='0; `err_o`=0; LFSRs = seeds.
- Grant is combinational (0 cycles). Read latency is exactly 1 cycle after grant. Back-to-back granted reads give one r_valid per cycle.
- Channels are independent, so `tcdm_gnt_o` bits may differ within a cycle. The streamer ANDs them; this block does not synchronise channels.
- Reset asserted mid-transaction: a pending r_valid is dropped (0 while `rst_i` is high). Writes in that cycle are not performed.
- `stall_thresh_i`=255 with `stallable_i`=1: a grant occurs only when lfsr[7:0]==255.

## Configuration
- `TCDM_RESP_STALL_EN`:
  - defined: LFSRs and the stall logic are compiled in, as described above;
  - undefined: no LFSRs, `tcdm_gnt_o = tcdm_req_i`, and `stallable_i`/`stall_thresh_i` are ignored.

## Test plan
- Setup for scenarios 1–4 and 6: reset, `stallable_i`=0, `MP`=4. Scenario 5 uses `stallable_i`=1.
1. Write 32'hDEADBEEF at byte address 0x40 on ch0 with be=4'hF, then read the same address on ch0 -> next cycle r_valid[0]=1, r_data[0]=32'hDEADBEEF.
2. Write 32'h11223344 to 0x80 with be=4'b0101 over a word preloaded with 0 -> a read returns 32'h00220044.
3. Same cycle: ch1 and ch3 write 0x100 with data 1 and 3, both with be=4'hF -> read returns 3. Same cycle: ch0 reads 0x100 while ch2 writes 7 to it -> the read returns the old value 3, and a later read returns 7.
4. Read address `MEM_WORDS*4 + 8` -> returns the word at index 2, and `err_o`=1 stays high until `rst_i` pulses.
5. With the macro defined, `stallable_i`=1, `stall_thresh_i`=26, 10,000 held requests per channel -> grant ratio 0.90±0.02, no request lost, every granted read gets exactly one r_valid. Repeat with `stall_thresh_i`=0 -> 100% grants.
6. Assert `rst_i` in the cycle after a granted read -> r_valid stays 0 that cycle, and memory contents are unchanged after reset.
